coprocessor0: RTL and testbench

MIPS coprocessor-0 register file, the consuming end of the writeback-to-CP0 channel. It accepts `WBToCP0Data` from the writeback stage and holds BadVAddr, Count, Compare, Status, Cause and EPC. It serves `mfc0` reads, records exceptions and `eret`, runs the Count/Compare timer, and raises the interrupt request the pipeline uses to flush.

---
 rtl/coprocessor0_pkg.sv | 65 ++++++
 rtl/coprocessor0_timer.sv | 48 ++++
 rtl/coprocessor0.sv | 120 ++++++++++++
 tb/tb_coprocessor0.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coprocessor0_pkg.sv
// coprocessor0_params: shared types and constants for the CP0 register file.
//   - CP0 register addresses and exception codes
//   - write masks for Status and Cause
//   - WBToCP0Data: the per-cycle request from the writeback stage
//   - StatusData / CauseData: bit layouts of the Status and Cause registers
package coprocessor0_params;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status: IM[15:8], EXL[1], IE[0].  Cause: software IP[9:8] only.
    localparam logic [31:0] STATUS_WRITE_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WRITE_MASK  = 32'h0000_0300;
    // BEV is hard-wired to 1, everything else clears.
    localparam logic [31:0] STATUS_RESET      = 32'h0040_0000;

    typedef struct packed {
        logic        write_enable;
        logic [4:0]  address_register;
        logic [2:0]  select;
        logic [31:0] write_data;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic [31:0] exception_address;
        logic        in_delay_slot;
        logic        eret_flish;
    } WBToCP0Data;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } StatusData;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } CauseData;

    function automatic logic is_address_error(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/coprocessor0_timer.sv
// cp0_timer: Count/Compare timer of CP0.
//   clock, reset_n     clock and async active-low reset
//   count_write        load Count from write_data
//   compare_write      load Compare from write_data, clears TI
//   write_data         mtc0 data
//   count, compare     current register values
//   timer_interrupt    TI, sticky until the next Compare write
module cp0_timer
    import coprocessor0_params::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        count_write,
    input  logic        compare_write,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_interrupt
);

    logic tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick            <= 1'b0;
            count           <= '0;
            compare         <= '0;
            timer_interrupt <= 1'b0;
        end else begin
            // Tick free-runs; a Count write does not disturb its phase.
            tick <= ~tick;

            if (count_write)
                count <= write_data;
            else if (tick)
                count <= count + 32'd1;

            // Compare write wins over a same-cycle match.
            if (compare_write) begin
                compare         <= write_data;
                timer_interrupt <= 1'b0;
            end else if ((count == compare) && (compare != '0)) begin
                timer_interrupt <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/coprocessor0.sv
// coprocessor0: MIPS CP0 register file fed by the writeback stage.
//   clock, reset_n      clock and async active-low reset
//   wb_to_cp0           mtc0 write / exception / eret request (this cycle only)
//   wb_bad_vaddr        faulting address, captured for AdEL/AdES
//   ext_interrupt       level hardware interrupts, [5] = IP7
//   read_data           mfc0 read of the addressed register (combinational)
//   epc                 current EPC, eret target
//   interrupt_pending   interrupt request to writeback
//   exception_target    fixed exception vector
module coprocessor0
    import coprocessor0_params::*;
#(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380
) (
    input  logic        clock,
    input  logic        reset_n,
    input  WBToCP0Data  wb_to_cp0,
    input  logic [31:0] wb_bad_vaddr,
    input  logic [5:0]  ext_interrupt,
    output logic [31:0] read_data,
    output logic [31:0] epc,
    output logic        interrupt_pending,
    output logic [31:0] exception_target
);

    StatusData   status_q;
    CauseData    cause_q;
    CauseData    cause_view;
    logic [31:0] epc_q;
    logic [31:0] bad_vaddr_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_interrupt;

    logic mtc0_valid;
    logic count_write;
    logic compare_write;

    // An exception in the same cycle suppresses any mtc0.
    assign mtc0_valid    = wb_to_cp0.write_enable && (wb_to_cp0.select == 3'd0)
                           && !wb_to_cp0.exception_valid;
    assign count_write   = mtc0_valid && (wb_to_cp0.address_register == CP0_COUNT);
    assign compare_write = mtc0_valid && (wb_to_cp0.address_register == CP0_COMPARE);

    cp0_timer u_timer (
        .clock           (clock),
        .reset_n         (reset_n),
        .count_write     (count_write),
        .compare_write   (compare_write),
        .write_data      (wb_to_cp0.write_data),
        .count           (count),
        .compare         (compare),
        .timer_interrupt (timer_interrupt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q    <= StatusData'(STATUS_RESET);
            cause_q     <= '0;
            epc_q       <= '0;
            bad_vaddr_q <= '0;
        end else begin
            // Hardware IP bits are sampled every cycle; mtc0 Cause only
            // touches the software bits, so both can land together.
            cause_q.ip[7:2] <= ext_interrupt;

            if (wb_to_cp0.exception_valid) begin
                if (!status_q.exl) begin
                    epc_q      <= wb_to_cp0.exception_address;
                    cause_q.bd <= wb_to_cp0.in_delay_slot;
                end
                status_q.exl     <= 1'b1;
                cause_q.exc_code <= wb_to_cp0.exception_code;
                if (is_address_error(wb_to_cp0.exception_code))
                    bad_vaddr_q <= wb_bad_vaddr;
            end else begin
                if (wb_to_cp0.eret_flish)
                    status_q.exl <= 1'b0;
                if (mtc0_valid) begin
                    case (wb_to_cp0.address_register)
                        CP0_STATUS: status_q <= StatusData'(
                                        (32'(status_q) & ~STATUS_WRITE_MASK) |
                                        (wb_to_cp0.write_data & STATUS_WRITE_MASK));
                        CP0_CAUSE:  cause_q.ip[1:0] <= wb_to_cp0.write_data[9:8];
                        CP0_EPC:    epc_q <= wb_to_cp0.write_data;
                        default:    ;
                    endcase
                end
            end
        end
    end

    // TI is owned by the timer and also folds into IP7.
    always_comb begin
        cause_view       = cause_q;
        cause_view.ti    = timer_interrupt;
        cause_view.ip[7] = cause_q.ip[7] | timer_interrupt;
    end

    always_comb begin
        read_data = '0;
        if (wb_to_cp0.select == 3'd0) begin
            case (wb_to_cp0.address_register)
                CP0_BADVADDR: read_data = bad_vaddr_q;
                CP0_COUNT:    read_data = count;
                CP0_COMPARE:  read_data = compare;
                CP0_STATUS:   read_data = 32'(status_q);
                CP0_CAUSE:    read_data = 32'(cause_view);
                CP0_EPC:      read_data = epc_q;
                default:      read_data = '0;
            endcase
        end
    end

    assign epc               = epc_q;
    assign interrupt_pending = status_q.ie & ~status_q.exl
                               & (|(cause_view.ip & status_q.im));
    assign exception_target  = EXCEPTION_VECTOR;

endmodule

// File: tb/tb_coprocessor0.sv
// Scoreboard bench for coprocessor0: the driver pushes expected values as it
// drives each cycle; a monitor on the falling edge pops and compares them.
module tb_coprocessor0;
    import coprocessor0_params::*;

    logic        clock;
    logic        reset_n;
    WBToCP0Data  wb;
    logic [31:0] wb_bad_vaddr;
    logic [5:0]  ext_interrupt;
    logic [31:0] read_data;
    logic [31:0] epc;
    logic        interrupt_pending;
    logic [31:0] exception_target;

    coprocessor0 dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_to_cp0         (wb),
        .wb_bad_vaddr      (wb_bad_vaddr),
        .ext_interrupt     (ext_interrupt),
        .read_data         (read_data),
        .epc               (epc),
        .interrupt_pending (interrupt_pending),
        .exception_target  (exception_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 read_data, 1 epc, 2 interrupt_pending, 3 exception_target
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge clock) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                0:       mon_act = read_data;
                1:       mon_act = epc;
                2:       mon_act = {31'b0, interrupt_pending};
                default: mon_act = exception_target;
            endcase
            checks++;
            if (mon_act !== mon_e.value) begin
                errors++;
                $display("FAIL %s: got %h, required %h", mon_e.name, mon_act, mon_e.value);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        wb = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wb.write_enable     = 1'b1;
        wb.address_register = a;
        wb.select           = 3'd0;
        wb.write_data       = d;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] addr,
                       input logic ds, input logic [31:0] bv);
        wb.exception_valid   = 1'b1;
        wb.exception_code    = code;
        wb.exception_address = addr;
        wb.in_delay_slot     = ds;
        wb_bad_vaddr         = bv;
    endtask

    task automatic expect_read(input logic [4:0] a, input logic [31:0] v, input string n);
        exp_t e;
        wb.address_register = a;
        wb.select           = 3'd0;
        e.kind = 0; e.value = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic expect_read_sel(input logic [4:0] a, input logic [2:0] s,
                                   input logic [31:0] v, input string n);
        exp_t e;
        wb.address_register = a;
        wb.select           = s;
        e.kind = 0; e.value = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic expect_out(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k; e.value = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        wb            = '0;
        wb_bad_vaddr  = '0;
        ext_interrupt = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state
        expect_read(CP0_COUNT, 32'h0, "reset_count");
        expect_out(1, 32'h0, "reset_epc");
        expect_out(2, 32'h0, "reset_irq");
        expect_out(3, 32'hBFC0_0380, "exception_target");
        step(); expect_read(CP0_STATUS,   32'h0040_0000, "reset_status");
        step(); expect_read(CP0_CAUSE,    32'h0, "reset_cause");
        step(); expect_read(CP0_EPC,      32'h0, "reset_epc_read");
        step(); expect_read(CP0_BADVADDR, 32'h0, "reset_badvaddr");
        step(); expect_read(CP0_COMPARE,  32'h0, "reset_compare");

        // Write masking
        step(); mtc0(CP0_STATUS, 32'hFFFF_FFFF); expect_read(CP0_STATUS, 32'h0040_0000, "status_prewrite");
        step(); expect_read(CP0_STATUS, 32'h0040_FF03, "status_mask");
        step(); mtc0(CP0_CAUSE, 32'hFFFF_FFFF); expect_read(CP0_CAUSE, 32'h0, "cause_prewrite");
        step(); expect_read(CP0_CAUSE, 32'h0000_0300, "cause_mask"); expect_out(2, 32'h0, "irq_masked_by_exl");
        step(); mtc0(5'd3, 32'hFFFF_FFFF);
        step(); expect_read(5'd3, 32'h0, "unsupported_addr");
        step(); expect_read_sel(CP0_STATUS, 3'd1, 32'h0, "nonzero_select");
        step(); mtc0(CP0_CAUSE, 32'h0);
        step(); mtc0(CP0_STATUS, 32'h0);

        // Software interrupt, masked by EXL, restored by eret
        step(); mtc0(CP0_STATUS, 32'h0000_0101);
        step(); mtc0(CP0_CAUSE, 32'h0000_0100); expect_out(2, 32'h0, "sw_irq_before");
        step(); expect_out(2, 32'h1, "sw_irq"); expect_read(CP0_CAUSE, 32'h0000_0100, "cause_sw");
        step(); exc(EXC_SYS, 32'hBFC0_2000, 1'b0, 32'h0); expect_out(2, 32'h1, "irq_before_exc");
        step(); expect_out(2, 32'h0, "irq_exl");
                expect_read(CP0_STATUS, 32'h0040_0103, "status_exl");
                expect_out(1, 32'hBFC0_2000, "epc_sys");
        step(); expect_read(CP0_CAUSE, 32'h0000_0120, "cause_sys");
        step(); wb.eret_flish = 1'b1;
        step(); expect_out(2, 32'h1, "irq_after_eret"); expect_read(CP0_STATUS, 32'h0040_0101, "status_eret");
        step(); mtc0(CP0_CAUSE, 32'h0);
        step(); mtc0(CP0_STATUS, 32'h0);

        // Exception vs. same-cycle write, nested exceptions, eret
        step(); exc(EXC_ADEL, 32'hBFC0_1000, 1'b1, 32'h1234_5671); mtc0(CP0_EPC, 32'h0);
                expect_read(CP0_EPC, 32'hBFC0_2000, "epc_prewrite");
        step(); expect_read(CP0_EPC, 32'hBFC0_1000, "epc_exc_beats_write");
                expect_out(1, 32'hBFC0_1000, "epc_port");
        step(); expect_read(CP0_CAUSE, 32'h8000_0010, "cause_adel");
        step(); expect_read(CP0_BADVADDR, 32'h1234_5671, "badvaddr_adel");
        step(); expect_read(CP0_STATUS, 32'h0040_0002, "status_exl_set");
        step(); exc(EXC_ADES, 32'hBFC0_3000, 1'b0, 32'hDEAD_BEEC);
        step(); expect_out(1, 32'hBFC0_1000, "epc_nested"); expect_read(CP0_CAUSE, 32'h8000_0014, "cause_nested");
        step(); expect_read(CP0_BADVADDR, 32'hDEAD_BEEC, "badvaddr_ades");
        step(); exc(EXC_OV, 32'hBFC0_4000, 1'b0, 32'h1111_1111);
        step(); expect_read(CP0_BADVADDR, 32'hDEAD_BEEC, "badvaddr_kept");
        step(); expect_read(CP0_CAUSE, 32'h8000_0030, "cause_ov");
        step(); exc(EXC_BP, 32'hBFC0_4100, 1'b0, 32'h0); wb.eret_flish = 1'b1;
        step(); expect_read(CP0_STATUS, 32'h0040_0002, "exc_beats_eret");
        step(); wb.eret_flish = 1'b1;
        step(); expect_read(CP0_STATUS, 32'h0040_0000, "eret_clears_exl");
        step(); exc(EXC_RI, 32'hBFC0_5000, 1'b0, 32'h0); mtc0(CP0_STATUS, 32'h0000_0001);
        step(); expect_read(CP0_STATUS, 32'h0040_0002, "exc_beats_status_write");
                expect_out(1, 32'hBFC0_5000, "epc_ri");
        step(); wb.eret_flish = 1'b1;

        // External interrupts: one-cycle lag, masking, IP sampling with mtc0 Cause
        step(); mtc0(CP0_STATUS, 32'h0000_8001);
        step(); ext_interrupt = 6'b100000; expect_out(2, 32'h0, "ext_irq_lag");
        step(); expect_out(2, 32'h1, "ext_irq"); expect_read(CP0_CAUSE, 32'h0000_8028, "cause_ip7");
                ext_interrupt = 6'b000000;
        step(); expect_out(2, 32'h0, "ext_irq_drop");
                ext_interrupt = 6'b000010; mtc0(CP0_CAUSE, 32'h0000_0200);
        step(); expect_read(CP0_CAUSE, 32'h0000_0A28, "cause_ip_and_write");
                expect_out(2, 32'h0, "irq_im_masked");
                ext_interrupt = 6'b000000;
        step(); mtc0(CP0_CAUSE, 32'h0);

        // Timer: Compare=10, Count=0 in cycle C, then cycles C+n
        do_reset();
        step(); mtc0(CP0_COMPARE, 32'd10);
        step(); mtc0(CP0_COUNT, 32'd0);
        step(); mtc0(CP0_STATUS, 32'h0000_8001);
        for (int n = 2; n <= 30; n++) begin
            step();
            case (n)
                5:  expect_read(CP0_COUNT, 32'd2, "count_n5");
                6:  expect_read(CP0_COUNT, 32'd3, "count_n6");
                20: expect_out(2, 32'h0, "timer_not_yet");
                22: begin
                        expect_out(2, 32'h1, "timer_irq");
                        expect_read(CP0_CAUSE, 32'h4000_8000, "cause_ti");
                    end
                23: begin
                        mtc0(CP0_COMPARE, 32'd10);
                        expect_out(2, 32'h1, "ti_held");
                    end
                24: begin
                        expect_out(2, 32'h0, "ti_cleared");
                        expect_read(CP0_CAUSE, 32'h0, "cause_ti_cleared");
                    end
                25: mtc0(CP0_COUNT, 32'd10);
                26: mtc0(CP0_COMPARE, 32'd10);
                27: begin
                        expect_out(2, 32'h0, "compare_write_beats_match");
                        expect_read(CP0_COUNT, 32'd10, "count_write_beats_tick");
                    end
                28: begin
                        expect_out(2, 32'h1, "ti_rematch");
                        expect_read(CP0_COUNT, 32'd11, "count_after_rematch");
                    end
                29: mtc0(CP0_COMPARE, 32'd0);
                30: expect_out(2, 32'h0, "ti_cleared_again");
                default: ;
            endcase
        end

        // Asynchronous reset between edges with Count=100, EXL=1
        step(); mtc0(CP0_COUNT, 32'd100);
        step(); exc(EXC_SYS, 32'hBFC0_6000, 1'b0, 32'h0);
        step(); expect_out(1, 32'hBFC0_6000, "epc_before_reset");
        step(); mtc0(CP0_COUNT, 32'd55);
                #2 reset_n = 1'b0;
                expect_read(CP0_COUNT, 32'h0, "count_async_reset");
                expect_out(1, 32'h0, "epc_async_reset");
                expect_out(2, 32'h0, "irq_async_reset");
        step(); expect_read(CP0_STATUS, 32'h0040_0000, "status_in_reset");
        step(); expect_read(CP0_CAUSE, 32'h0, "cause_in_reset");
        step(); reset_n = 1'b1;
                expect_read(CP0_COUNT, 32'h0, "count_after_release");
                expect_out(1, 32'h0, "epc_after_release");

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
